// File: rtl/mdu.sv
// Multiply/divide unit beside the ALU: owns HI/LO, runs fixed-latency
// MULT/DIV ops. Optional MADD/MADDU when MDU_MADD_EN is defined.
// Ports: clk, reset (async high), Start, MDUOp[3:0], SrcA, SrcB,
//        Busy, HI, LO, MDUOut (HI/LO read mux for MFHI/MFLO).
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d, cnt_q, cnt_d;

  logic        madd_ok;
  logic        accept;
  logic        is_mul, is_div;
  logic [63:0] smul, umul, hilo;
  logic [31:0] ua, ub, uq, ur, sq, sr;
  logic        a_neg, b_neg;

`ifdef MDU_MADD_EN
  assign madd_ok = 1'b1;
`else
  assign madd_ok = 1'b0;
`endif

  assign Busy = (cnt_q != 4'd0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == OP_MFHI) MDUOut = hi_q;
    else if (MDUOp == OP_MFLO) MDUOut = lo_q;
  end

  assign is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                  (madd_ok && ((MDUOp == OP_MADD) || (MDUOp == OP_MADDU)));
  assign is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
  assign accept = Start && !Busy;

  // Arithmetic on latched operands, consumed on the completion edge.
  assign hilo  = {hi_q, lo_q};
  assign smul  = $signed({{32{a_q[31]}}, a_q}) *
                 $signed({{32{b_q[31]}}, b_q});
  assign umul  = {32'd0, a_q} * {32'd0, b_q};
  assign a_neg = a_q[31];
  assign b_neg = b_q[31];
  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly.
  assign ua    = a_neg ? (32'd0 - a_q) : a_q;
  assign ub    = b_neg ? (32'd0 - b_q) : b_q;
  assign uq    = (ub == 32'd0) ? 32'd0 : ua / ub;
  assign ur    = (ub == 32'd0) ? 32'd0 : ua % ub;
  assign sq    = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign sr    = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    if (accept && (is_mul || is_div)) begin
      a_d   = SrcA;
      b_d   = SrcB;
      op_d  = MDUOp;
      cnt_d = is_mul ? 4'd5 : 4'd10;
    end else if (accept && MDUOp == OP_MTHI) begin
      hi_d = SrcA;
    end else if (accept && MDUOp == OP_MTLO) begin
      lo_d = SrcA;
    end
    if (cnt_q == 4'd1) begin
      unique case (op_q)
        OP_MULT:  {hi_d, lo_d} = smul;
        OP_MULTU: {hi_d, lo_d} = umul;
        OP_DIV: begin
          if (b_q != 32'd0) begin
            hi_d = sr;
            lo_d = sq;
          end
        end
        OP_DIVU: begin
          if (b_q != 32'd0) begin
            hi_d = a_q % b_q;
            lo_d = a_q / b_q;
          end
        end
        OP_MADD:  if (madd_ok) {hi_d, lo_d} = hilo + smul;
        OP_MADDU: if (madd_ok) {hi_d, lo_d} = hilo + umul;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 4'd0;
      cnt_q <= 4'd0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 Start  input  1  qualifies MDUOp as an issued operation this cycle.
REQ-004 MDUOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU; 11-15 treated as NONE.
REQ-005 SrcA  input  32  first operand, taken from the same forwarded rs value the ALU receives.
REQ-006 SrcB  input  32  second operand, taken from the same forwarded rt value the ALU receives.
REQ-007 Busy  output  1  high while a multiply or divide is in flight.
REQ-008 HI  output  32  architectural HI register.
REQ-009 LO  output  32  architectural LO register.
REQ-010 MDUOut  output  32  read result: HI when MDUOp=MFHI, LO when MDUOp=MFLO, else 0; combinational, independent of Start.

Function
REQ-011 The block SHALL sit beside the ALU in the execute stage, consuming the same operands; MDUOut SHALL be muxed with ALUResult downstream.
REQ-012 An op is accepted at a rising edge when Start=1, Busy=0 and MDUOp is 1-10 (9-10 only per REQ-024); Start while Busy=1 SHALL be ignored with no state change.
REQ-013 On accepting MULT/MULTU/DIV/DIVU/MADD/MADDU, SrcA, SrcB and the op SHALL be latched, and a cycle counter SHALL be loaded with 5 for multiply-class ops and 10 for divide ops.
REQ-014 Busy SHALL equal (counter != 0); the counter SHALL decrement by one each edge while nonzero, so Busy is high for exactly 5 or 10 cycles after the accept edge.
REQ-015 HI/LO SHALL change only on the edge where the counter goes 1->0; HI/LO SHALL hold their old values for the whole Busy window.
REQ-016 MULT: {HI,LO} = signed(SrcA) * signed(SrcB), full 64-bit product; MULTU: the unsigned 64-bit product.
REQ-017 DIV: LO = signed quotient truncated toward zero, HI = remainder carrying the dividend's sign; DIVU: the unsigned quotient and remainder.
REQ-018 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 Divide by zero SHALL still run the full 10 busy cycles and SHALL leave HI and LO unchanged.
REQ-020 MTHI/MTLO accepted SHALL write SrcA into HI/LO at that edge, with Busy remaining 0.
REQ-021 MFHI/MFLO and NONE SHALL not modify state; MDUOut SHALL reflect the current HI/LO, including on the first cycle after Busy falls.
REQ-022 The hazard unit stalls MDU ops and MF/MT while Busy=1; the block itself SHALL rely only on REQ-012 for protection.

Reset
REQ-023 On reset assertion, immediately and regardless of clk: HI=0, LO=0, counter=0, Busy=0, latched operands and op cleared; an in-flight operation SHALL be aborted with no HI/LO write after reset releases.

Configuration
REQ-024 Macro MDU_MADD_EN. When defined, MADD/MADDU SHALL add the signed/unsigned 64-bit product of SrcA and SrcB to the {HI,LO} value sampled at completion, modulo 2^64, with 5-cycle latency. When undefined, ops 9-10 SHALL be treated as NONE: not accepted, Busy not raised, no state change.

Verification
REQ-025 reset pulse mid-DIV (cycle 4 of 10) -> Busy=0, HI=LO=0 immediately, and both stay 0 after release.
REQ-026 MULT SrcA=0xFFFFFFFE, SrcB=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; the MULTU form gives HI=0x00000002, LO=0xFFFFFFFA.
REQ-027 DIV SrcA=0xFFFFFFF9 (-7), SrcB=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 with prior HI=0x11, LO=0x22 -> both unchanged.
REQ-028 MULT issued, second Start=1 with MTLO SrcA=0x55 at Busy cycle 2 -> MTLO ignored; LO ends as the product.
REQ-029 MTHI SrcA=0x1234 then next cycle MDUOp=MFHI -> MDUOut=0x1234, Busy stays 0 throughout.
REQ-030 with MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0; without the macro the same stimulus -> Busy=0, HI/LO unchanged.
